// File: rtl/serialize_word_to_bit_stream_pkg.sv
// Shared types and sizing helpers for the word-to-bit serializer.
package serialize_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   // Bit counter width: it must hold W-1.
   function automatic int cnt_w(input int w);
      return $clog2(w);
   endfunction

endpackage

// File: rtl/serialize_word_to_bit_stream_word_hold_buffer.sv
// Single-entry holding register between the word handshake and the shifter.
module word_hold_buffer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         full_nxt,
   output logic         ready
);

   // A write only happens while empty, so write and read never collide.
   always_comb begin
      full_nxt = full;
      if (wr_en) begin
         full_nxt = 1'b1;
      end else if (rd_en) begin
         full_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         full  <= 1'b0;
         ready <= 1'b0;
      end else begin
         full  <= full_nxt;
         ready <= !full_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         rd_data <= wr_data;
      end
   end

endmodule

// File: rtl/serialize_word_to_bit_stream.sv
// Parallel-in, serial-out stage: W-bit words in over valid/ready, one bit per clock out on a.
module serialize_word_to_bit_stream
   import serialize_pkg::*;
#(
   parameter int   W         = 8,
   parameter int   MSB_FIRST = 1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] data_in,
   input  logic         data_valid,
   output logic         data_ready,
   output logic         a,
   output logic         a_valid,
   output logic         word_start,
   output logic         idle
);

   localparam int CW = cnt_w(W);

   if (W < 2) begin : g_bad_w
      $error("serialize_word_to_bit_stream: W must be at least 2");
   end

   ser_state_t    state, state_n;
   logic [CW-1:0] bit_cnt, bit_cnt_n;
   logic [W-1:0]  shreg, shreg_n, buf_data;
   logic          buf_full, buf_full_n, load, wr;

   function automatic logic first_bit(input logic [W-1:0] v);
      return (MSB_FIRST != 0) ? v[W-1] : v[0];
   endfunction

   assign wr = data_valid & data_ready;

   word_hold_buffer #(.W(W)) u_buf (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr),
      .wr_data  (data_in),
      .rd_en    (load),
      .rd_data  (buf_data),
      .full     (buf_full),
      .full_nxt (buf_full_n),
      .ready    (data_ready)
   );

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (buf_full) begin
               load    = 1'b1;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (bit_cnt != '0) begin
               bit_cnt_n = bit_cnt - CW'(1);
               shreg_n   = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
            end else if (buf_full) begin
               load = 1'b1;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      // A reload on the last bit keeps the stream gap-free.
      if (load) begin
         shreg_n   = buf_data;
         bit_cnt_n = CW'(W - 1);
      end
   end

   // Outputs are registered from next-state values so the first bit appears right after the load edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         a          <= IDLE_BIT;
         a_valid    <= 1'b0;
         word_start <= 1'b0;
         idle       <= 1'b1;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         a          <= (state_n == SHIFT) ? first_bit(shreg_n) : IDLE_BIT;
         a_valid    <= (state_n == SHIFT);
         word_start <= load;
         idle       <= (state_n == IDLE) && !buf_full_n;
      end
   end

   always_ff @(posedge clk) begin
      shreg <= shreg_n;
   end

endmodule

// File: tb/tb_serialize_word_to_bit_stream.sv
// Randomized bench: two serializer instances (MSB/idle-0 and LSB/idle-1) against a timeline model.
module tb_serialize_word_to_bit_stream;

   localparam int W    = 8;
   localparam int NCYC = 3200;

   typedef struct {
      logic [W-1:0] w;
      int           k;
      int           s;
   } word_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         data_valid;
   logic [W-1:0] data_in;
   logic         rdy [2];
   logic         a   [2];
   logic         av  [2];
   logic         ws  [2];
   logic         idl [2];

   int     n_checks = 0;
   int     n_fail   = 0;
   int     cyc      = 0;
   int     next_free = 0;
   bit     in_rst   = 1'b1;
   word_t  q[$];

   logic         e_rdy, e_av, e_ws, e_idle;
   logic [W-1:0] e_word;
   int           e_idx;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      serialize_word_to_bit_stream #(
         .W         (W),
         .MSB_FIRST (g == 0 ? 1 : 0),
         .IDLE_BIT  (g == 0 ? 1'b0 : 1'b1)
      ) dut (
         .clk        (clk),
         .rst        (rst),
         .data_in    (data_in),
         .data_valid (data_valid),
         .data_ready (rdy[g]),
         .a          (a[g]),
         .a_valid    (av[g]),
         .word_start (ws[g]),
         .idle       (idl[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Each accepted word occupies the buffer from its handshake until its first bit,
   // then emits W bits starting at max(handshake+1, end of previous word).
   task automatic model_edge(input logic r, input logic dv, input logic [W-1:0] d, input logic prev_rdy);
      word_t e;
      cyc++;
      if (!r) begin
         q.delete();
         next_free = 0;
         in_rst    = 1'b1;
      end else begin
         in_rst = 1'b0;
         if (dv && prev_rdy) begin
            e.w = d;
            e.k = cyc;
            e.s = (cyc + 1 > next_free) ? cyc + 1 : next_free;
            next_free = e.s + W;
            q.push_back(e);
         end
         while (q.size() > 0 && q[0].s + W <= cyc) void'(q.pop_front());
      end
   endtask

   task automatic model_expect();
      e_rdy  = !in_rst;
      e_av   = 1'b0;
      e_ws   = 1'b0;
      e_idle = 1'b1;
      e_word = '0;
      e_idx  = 0;
      foreach (q[i]) begin
         if (cyc >= q[i].k && cyc < q[i].s) e_rdy = 1'b0;
         if (cyc >= q[i].k && cyc < q[i].s + W) e_idle = 1'b0;
         if (cyc >= q[i].s && cyc < q[i].s + W) begin
            e_av   = 1'b1;
            e_word = q[i].w;
            e_idx  = cyc - q[i].s;
            e_ws   = (e_idx == 0);
         end
      end
   endtask

   initial begin
      logic         prev_rdy;
      logic         e_a;
      logic [W-1:0] dir_w [7];
      int           cnt;
      int           mode;
      dir_w    = '{8'hCC, 8'hA5, 8'h3C, 8'h01, 8'hFF, 8'h0F, 8'h81};
      prev_rdy = 1'b0;
      cnt      = 0;
      rst        = 1'b0;
      data_valid = 1'b0;
      data_in    = '0;
      for (int n = 0; n < NCYC; n++) begin
         @(posedge clk);
         if (rst && data_valid && prev_rdy) cnt++;
         model_edge(rst, data_valid, data_in, prev_rdy);
         model_expect();
         #1;
         mode = (n / 400) % 4;
         rst  = (n < 2 || $urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         case (mode)
            0: begin
               data_valid = 1'b1;
               if (e_rdy) data_in = (cnt < 7) ? dir_w[cnt] : W'(cnt);
               else       data_in = W'($urandom);
            end
            1: begin
               data_valid = ($urandom_range(0, 9) < 4);
               data_in    = W'($urandom);
            end
            2: begin
               data_valid = 1'b1;
               data_in    = W'($urandom);
            end
            default: begin
               data_valid = ($urandom_range(0, 9) == 0);
               data_in    = W'($urandom);
            end
         endcase
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (e_av) e_a = (i == 0) ? e_word[W-1-e_idx] : e_word[e_idx];
            else      e_a = (i == 0) ? 1'b0 : 1'b1;
            chk($sformatf("data_ready%0d", i), 32'(rdy[i]), 32'(e_rdy));
            chk($sformatf("a%0d", i),          32'(a[i]),   32'(e_a));
            chk($sformatf("a_valid%0d", i),    32'(av[i]),  32'(e_av));
            chk($sformatf("word_start%0d", i), 32'(ws[i]),  32'(e_ws));
            chk($sformatf("idle%0d", i),       32'(idl[i]), 32'(e_idle));
         end
         prev_rdy = e_rdy;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serialize_word_to_bit_stream.md
# serialize_word_to_bit_stream

Parallel-in, serial-out stage that sits directly upstream of the serial sequence detectors and drives their single-bit `a` input. It accepts W-bit words over a valid/ready handshake and emits them one bit per clock, in a configurable bit order, with a validity flag and a first-bit marker. A one-word holding buffer lets back-to-back words stream out with no gap. Idle cycles drive a fixed filler bit, so downstream detectors never see stale data.

## Interface
- `W`, default 8: word width in bits; must be at least 2.
- `MSB_FIRST`, default 1: 1 sends bit W-1 first; 0 sends bit 0 first.
- `IDLE_BIT`, default 0: value driven on `a` whenever `a_valid` = 0.
- `clk`  input  1: the only clock; all state updates on its rising edge.
- `rst`  input  1: synchronous, active-low reset; `rst` = 0 at a rising edge resets the block.
- `data_in`  input  W: word to serialize.
- `data_valid`  input  1: `data_in` holds a word.
- `data_ready`  output  1: block can accept a word this cycle.
- `a`  output  1: serial bit stream, connects to a detector's `a` input.
- `a_valid`  output  1: `a` carries a payload bit.
- `word_start`  output  1: high during the first bit of each word.
- `idle`  output  1: buffer and shifter both empty.

## Operation
- Handshake: a word is accepted in any cycle where `data_valid` and `data_ready` are both high. `data_ready` = NOT `buf_full`, driven from a register. No combinational path runs from `data_valid` to `data_ready`.
- An accepted word is written into the holding buffer at that clock edge, and `buf_full` sets.
- State machine, with states IDLE and SHIFT, plus `bit_cnt` of width clog2(W):
  - IDLE with `buf_full` = 1: load the shifter from the buffer, clear `buf_full`, set `bit_cnt` = W-1, go to SHIFT.
  - SHIFT: output one bit per cycle and decrement `bit_cnt`.
  - SHIFT with `bit_cnt` = 0 (last bit) and `buf_full` = 1: reload from the buffer, stay in SHIFT. No bubble.
  - SHIFT with `bit_cnt` = 0 and `buf_full` = 0: go to IDLE.
  - A word accepted in the same cycle the buffer unloads cannot happen, because `data_ready` was 0 in that cycle.
- Outputs, all registered:
  - `a` = current shifter output bit when in SHIFT, otherwise `IDLE_BIT`.
  - `a_valid` = (state == SHIFT).
  - `word_start` = 1 in the first SHIFT cycle after each load.
  - `idle` = (state == IDLE) AND NOT `buf_full`.
- The shifter shifts left when `MSB_FIRST` = 1 and right when 0. Bits shifted in are don't-care and never reach `a`.
- Reset (`rst` = 0), required values:
  - state = IDLE, `buf_full` = 0, `a` = `IDLE_BIT`, `a_valid` = 0, `word_start` = 0, `idle` = 1.
  - `data_ready` is forced 0 while `rst` = 0 and goes to 1 in the first cycle after release.
- Reset in the middle of a word discards the partial word and the buffered word. The next bit after release is `IDLE_BIT`.
- `data_valid` may drop without a handshake. A word offered while `data_ready` = 0 is not taken, and `data_in` is sampled only on a handshake.

## Timing
- Latency: handshake at edge k puts the first bit on `a` after edge k+1, i.e. 2 cycles from the handshake cycle to first `a_valid`.
- A word occupies exactly W consecutive `a_valid` cycles.
- Sustained throughput is one word per W cycles. A source that holds `data_valid` high gets gap-free output.
- `data_ready` rises the cycle after the buffer unloads. Because W ≥ 2, the next word is already buffered before the current word's last bit.
- `idle` rises the cycle after the last bit of the last word.

## Structure
- Package `serialize_pkg`:
  - state enum `ser_state_t` {IDLE, SHIFT}.
  - function `cnt_w(W)` returning clog2(W).
  - the W ≥ 2 constraint, checked by an elaboration-time assertion in the module.
- One sub-module is natural: `word_hold_buffer`. It is a single-entry W-bit register with a `full` flag, a write port (handshake) and a read/clear port (load). The top level holds the FSM, shifter and counter.

## Test plan
- **Single word:** W=8, `MSB_FIRST`=1, `IDLE_BIT`=0, one handshake of 8'hCC.
  - `a` = 1,1,0,0,1,1,0,0 with `a_valid` high for 8 cycles, starting 2 cycles after the handshake.
  - `word_start` is high on the first bit only, then `idle` = 1.
  - Chained into the "110011" detector, `detected` asserts once.
- **Back-to-back:** 8'hA5 then 8'h3C, offered with `data_valid` held high.
  - 16 contiguous `a_valid` cycles: 10100101 00111100.
  - `word_start` is high on bits 0 and 8.
  - `data_ready` is low for all but one cycle per word.
- **LSB first:** `MSB_FIRST`=0, word 8'h01.
  - `a` = 1,0,0,0,0,0,0,0.
- **Backpressure:** `data_valid` held high with a counting source 8'h00, 8'h01, 8'h02 ….
  - No word is lost or duplicated; output words arrive in order.
  - `data_in` changes while `data_ready` = 0 are ignored.
- **Reset mid-word:** `rst` = 0 for 1 cycle during bit 3 of 8'hFF, with 8'h0F buffered.
  - Afterwards `a_valid` = 0, `a` = `IDLE_BIT`, `idle` = 1.
  - The next handshake (8'h81) emits cleanly.
- **Idle fill:** `IDLE_BIT`=1 with a gap of 5 cycles between words.
  - `a` = 1 with `a_valid` = 0 throughout the gap.
